// File: rtl/int_ctl_pkg.sv
// int_ctl shared types and constants.
// Interrupt kinds, vector addresses and the BRK opcode.
package int_ctl_pkg;

    typedef enum logic [2:0] {
        KIND_NONE,
        KIND_RST,
        KIND_NMI,
        KIND_IRQ,
        KIND_BRK
    } int_kind_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;
    localparam logic [7:0]  OPC_BRK = 8'h00;

    // Hardware-injected sequences do not advance the PC.
    function automatic logic is_hw(input int_kind_t k);
        return (k == KIND_RST) || (k == KIND_NMI) || (k == KIND_IRQ);
    endfunction

endpackage

// File: rtl/int_ctl_sync_ff.sv
// Multi-flop synchronizer for an asynchronous active-low pin.
// Resets to 1 so a released pin reads as inactive.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    // Shift the pin through DEPTH flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '1;
        end else begin
            sr <= {sr[DEPTH-2:0], d};
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/int_ctl.sv
// Interrupt and reset sequencer for the 6502 core.
// Injects BRK at instruction boundaries and tracks the sequence kind.
module int_ctl
    import int_ctl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        sync,
    input  logic [7:0]  opcode_in,
    input  logic        i_flag,
    input  logic        vec_fetch,
    input  logic        brk_done,
    output logic [7:0]  opcode_out,
    output logic        int_active,
    output logic        wr_inhibit,
    output logic        push_b,
    output logic        set_i,
    output logic [15:0] vec_addr,
    output logic        nmi_pend
);

    logic      nmi_s;
    logic      irq_s;
    logic      nmi_hist;
    logic      rst_pend;
    logic      nmi_edge;
    logic      irq_req;
    logic      take_vec;
    logic      hijack;
    logic      nmi_clr;
    logic [15:0] vec_sel;
    int_kind_t kind;
    int_kind_t sel;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_nmi_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (nmi_n),
        .q     (nmi_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq_n),
        .q     (irq_s)
    );

    assign nmi_edge = nmi_hist && !nmi_s;
    assign irq_req  = !irq_s && !i_flag;

    // Boundary choice, highest priority first.
    always_comb begin
        sel = KIND_NONE;
        unique case (1'b1)
            rst_pend:
                sel = KIND_RST;
            !rst_pend && nmi_pend:
                sel = KIND_NMI;
            !rst_pend && !nmi_pend && irq_req:
                sel = KIND_IRQ;
            !rst_pend && !nmi_pend && !irq_req
                && (opcode_in == OPC_BRK):
                sel = KIND_BRK;
            default:
                sel = KIND_NONE;
        endcase
    end

    assign take_vec = vec_fetch && (kind != KIND_NONE);
    assign hijack   = nmi_pend
                   && ((kind == KIND_IRQ) || (kind == KIND_BRK));
    assign nmi_clr  = vec_fetch && ((kind == KIND_NMI) || hijack);

    // Vector for the current sequence; a pending NMI steals IRQ/BRK.
    always_comb begin
        vec_sel = VEC_IRQ;
        unique case (kind)
            KIND_RST: vec_sel = VEC_RST;
            KIND_NMI: vec_sel = VEC_NMI;
            KIND_IRQ,
            KIND_BRK: vec_sel = hijack ? VEC_NMI : VEC_IRQ;
            default:  vec_sel = VEC_IRQ;
        endcase
    end

    // Sequence kind, pending flags, NMI history and vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind     <= KIND_NONE;
            rst_pend <= 1'b1;
            nmi_pend <= 1'b0;
            nmi_hist <= 1'b1;
            vec_addr <= VEC_RST;
        end else begin
            nmi_hist <= nmi_s;
            nmi_pend <= nmi_edge || (nmi_pend && !nmi_clr);
            if (sync) begin
                kind     <= sel;
                rst_pend <= 1'b0;
            end else if (brk_done) begin
                kind <= KIND_NONE;
            end
            if (take_vec) begin
                vec_addr <= vec_sel;
            end
        end
    end

    assign opcode_out = (sync && is_hw(sel)) ? OPC_BRK : opcode_in;
    assign set_i      = take_vec;
    assign int_active = is_hw(kind);
    assign wr_inhibit = (kind == KIND_RST);
    assign push_b     = (kind == KIND_BRK);

endmodule

// File: tb/tb_int_ctl.sv
// Self-checking bench for int_ctl: directed test plan, then random traffic.
// A cycle-level reference model predicts every output.
module tb_int_ctl;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        sync = 1'b0;
    logic [7:0]  opcode_in = 8'hEA;
    logic        i_flag = 1'b1;
    logic        vec_fetch = 1'b0;
    logic        brk_done = 1'b0;
    logic [7:0]  opcode_out;
    logic        int_active;
    logic        wr_inhibit;
    logic        push_b;
    logic        set_i;
    logic [15:0] vec_addr;
    logic        nmi_pend;

    int n_cmp = 0;
    int n_bad = 0;

    string       m_seq;
    bit          m_rst_pend;
    bit          m_nmi_pend;
    logic [15:0] m_vec;
    bit          nq[$];
    bit          iq[$];

    int_ctl #(.SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nmi_n      (nmi_n),
        .irq_n      (irq_n),
        .sync       (sync),
        .opcode_in  (opcode_in),
        .i_flag     (i_flag),
        .vec_fetch  (vec_fetch),
        .brk_done   (brk_done),
        .opcode_out (opcode_out),
        .int_active (int_active),
        .wr_inhibit (wr_inhibit),
        .push_b     (push_b),
        .set_i      (set_i),
        .vec_addr   (vec_addr),
        .nmi_pend   (nmi_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit hw(input string s);
        return (s == "RST") || (s == "NMI") || (s == "IRQ");
    endfunction

    // Pin values seen SYNC-1 edges ago are what the core acts on now.
    function automatic string m_sel();
        bit irq_req;
        irq_req = !iq[$-(SYNC-1)] && !i_flag;
        if (m_rst_pend)             return "RST";
        if (m_nmi_pend)             return "NMI";
        if (irq_req)                return "IRQ";
        if (opcode_in == 8'h00)     return "BRK";
        return "NONE";
    endfunction

    task automatic model_init();
        m_seq      = "NONE";
        m_rst_pend = 1'b1;
        m_nmi_pend = 1'b0;
        m_vec      = 16'hFFFC;
        nq.delete();
        iq.delete();
        repeat (SYNC + 1) begin
            nq.push_back(1'b1);
            iq.push_back(1'b1);
        end
    endtask

    task automatic observe();
        string s;
        @(negedge clk);
        s = m_sel();
        chk("opcode_out", 16'(opcode_out),
            16'((sync && hw(s)) ? 8'h00 : opcode_in));
        chk("set_i", 16'(set_i), 16'(vec_fetch && (m_seq != "NONE")));
        chk("int_active", 16'(int_active), 16'(hw(m_seq)));
        chk("wr_inhibit", 16'(wr_inhibit), 16'(m_seq == "RST"));
        chk("push_b", 16'(push_b), 16'(m_seq == "BRK"));
        chk("vec_addr", vec_addr, m_vec);
        chk("nmi_pend", 16'(nmi_pend), 16'(m_nmi_pend));
    endtask

    task automatic advance();
        string s;
        bit    edge_now;
        bit    clr;
        s        = m_sel();
        edge_now = nq[$-SYNC] && !nq[$-(SYNC-1)];
        clr      = vec_fetch && ((m_seq == "NMI")
                   || (((m_seq == "IRQ") || (m_seq == "BRK")) && m_nmi_pend));
        if (vec_fetch && (m_seq != "NONE")) begin
            if (m_seq == "RST")
                m_vec = 16'hFFFC;
            else if ((m_seq == "NMI") || m_nmi_pend)
                m_vec = 16'hFFFA;
            else
                m_vec = 16'hFFFE;
        end
        m_nmi_pend = edge_now || (m_nmi_pend && !clr);
        if (sync) begin
            m_seq      = s;
            m_rst_pend = 1'b0;
        end else if (brk_done) begin
            m_seq = "NONE";
        end
        nq.push_back(nmi_n);
        iq.push_back(irq_n);
        while (nq.size() > SYNC + 2) void'(nq.pop_front());
        while (iq.size() > SYNC + 2) void'(iq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        observe();
        advance();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sync      = 1'b0;
        vec_fetch = 1'b0;
        brk_done  = 1'b0;
        #1;
        model_init();
        observe();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_int_active", 16'(int_active), 16'h0);
        chk("rst_vec_addr", vec_addr, 16'hFFFC);
        chk("rst_nmi_pend", 16'(nmi_pend), 16'h0);

        // Reset sequence on the first boundary
        sync = 1'b1; opcode_in = 8'hA9;
        observe();
        chk("rst_inject", 16'(opcode_out), 16'h00);
        advance();
        sync = 1'b0;
        observe();
        chk("rst_wr_inhibit", 16'(wr_inhibit), 16'h1);
        chk("rst_active", 16'(int_active), 16'h1);
        advance();
        vec_fetch = 1'b1;
        observe();
        chk("rst_set_i", 16'(set_i), 16'h1);
        advance();
        vec_fetch = 1'b0; brk_done = 1'b1;
        observe();
        chk("rst_vec", vec_addr, 16'hFFFC);
        advance();
        brk_done = 1'b0;
        observe();
        chk("rst_done_flags", 16'({int_active, wr_inhibit, push_b}), 16'h0);
        advance();

        // One-clock NMI pulse
        nmi_n = 1'b0;
        step();
        nmi_n = 1'b1;
        observe();
        chk("nmi_early", 16'(nmi_pend), 16'h0);
        advance();
        observe();
        chk("nmi_early2", 16'(nmi_pend), 16'h0);
        advance();
        sync = 1'b1; opcode_in = 8'hEA;
        observe();
        chk("nmi_latched", 16'(nmi_pend), 16'h1);
        chk("nmi_inject", 16'(opcode_out), 16'h00);
        advance();
        sync = 1'b0; vec_fetch = 1'b1;
        observe();
        chk("nmi_push_b", 16'(push_b), 16'h0);
        advance();
        vec_fetch = 1'b0; brk_done = 1'b1;
        observe();
        chk("nmi_vec", vec_addr, 16'hFFFA);
        chk("nmi_cleared", 16'(nmi_pend), 16'h0);
        advance();
        brk_done = 1'b0;

        // IRQ masked, then taken
        irq_n = 1'b0; i_flag = 1'b1;
        repeat (3) step();
        sync = 1'b1; opcode_in = 8'hEA;
        observe();
        chk("irq_masked", 16'(opcode_out), 16'hEA);
        advance();
        i_flag = 1'b0;
        observe();
        chk("irq_inject", 16'(opcode_out), 16'h00);
        advance();
        sync = 1'b0; vec_fetch = 1'b1;
        step();
        vec_fetch = 1'b0; brk_done = 1'b1;
        observe();
        chk("irq_vec", vec_addr, 16'hFFFE);
        chk("irq_push_b", 16'(push_b), 16'h0);
        advance();
        brk_done = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
        repeat (3) step();

        // Software BRK
        sync = 1'b1; opcode_in = 8'h00;
        step();
        sync = 1'b0;
        observe();
        chk("brk_active", 16'(int_active), 16'h0);
        chk("brk_push_b", 16'(push_b), 16'h1);
        advance();
        vec_fetch = 1'b1;
        step();
        vec_fetch = 1'b0; brk_done = 1'b1;
        observe();
        chk("brk_vec", vec_addr, 16'hFFFE);
        advance();
        brk_done = 1'b0;

        // NMI hijacks a BRK
        sync = 1'b1; opcode_in = 8'h00;
        step();
        sync = 1'b0; nmi_n = 1'b0;
        step();
        nmi_n = 1'b1;
        step();
        step();
        vec_fetch = 1'b1;
        observe();
        chk("hij_pend", 16'(nmi_pend), 16'h1);
        advance();
        vec_fetch = 1'b0;
        observe();
        chk("hij_vec", vec_addr, 16'hFFFA);
        chk("hij_push_b", 16'(push_b), 16'h1);
        chk("hij_cleared", 16'(nmi_pend), 16'h0);
        advance();
        brk_done = 1'b1;
        step();
        brk_done = 1'b0;

        // New NMI edge coincides with the vec_fetch clear
        nmi_n = 1'b0;
        step();
        nmi_n = 1'b1;
        step();
        step();
        sync = 1'b1; opcode_in = 8'hEA;
        step();
        sync = 1'b0; nmi_n = 1'b0;
        step();
        nmi_n = 1'b1;
        step();
        vec_fetch = 1'b1;
        step();
        vec_fetch = 1'b0;
        observe();
        chk("coin_pend", 16'(nmi_pend), 16'h1);
        chk("coin_vec", vec_addr, 16'hFFFA);
        advance();
        sync = 1'b1; brk_done = 1'b1; opcode_in = 8'h4C;
        observe();
        chk("coin_reinject", 16'(opcode_out), 16'h00);
        advance();
        sync = 1'b0; brk_done = 1'b0;
        observe();
        chk("coin_sync_wins", 16'(int_active), 16'h1);
        advance();
        vec_fetch = 1'b1;
        step();
        vec_fetch = 1'b0; brk_done = 1'b1;
        step();
        brk_done = 1'b0;

        // Random traffic against the model, with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) < 1) begin
                do_reset();
            end
            sync      = ($urandom_range(99) < 25);
            vec_fetch = ($urandom_range(99) < 20);
            brk_done  = ($urandom_range(99) < 15);
            opcode_in = ($urandom_range(99) < 30) ? 8'h00 : 8'($urandom);
            i_flag    = ($urandom_range(99) < 50);
            nmi_n     = ($urandom_range(99) >= 20);
            irq_n     = ($urandom_range(99) >= 40);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/int_ctl.md
# int_ctl

Interrupt and reset sequencer for the 6502 core. It sits between the opcode fetch path and `decode`. At each instruction boundary it chooses whether to pass the fetched opcode through or inject a BRK (8'h00) for reset, NMI or IRQ. It then tracks the resulting BRK-type sequence so that the cycle sequencer gets the right PC-increment suppression, write inhibit, pushed B flag and vector address.

## Interface
Parameters:
- SYNC_STAGES, default 2: number of synchronizer flops on `nmi_n` and `irq_n`. Minimum 2.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `nmi_n`  in  1  asynchronous NMI pin, active-low, edge-triggered.
- `irq_n`  in  1  asynchronous IRQ pin, active-low, level-sensitive.
- `sync`  in  1  instruction boundary: the opcode byte is on `opcode_in` this cycle.
- `opcode_in`  in  8  fetched opcode byte.
- `i_flag`  in  1  current P[2] (interrupt disable).
- `vec_fetch`  in  1  sequencer is issuing the vector low-byte read this cycle.
- `brk_done`  in  1  BRK-type sequence complete (PC loaded from vector).
- `opcode_out`  out  8  opcode forwarded to `decode`.
- `int_active`  out  1  current sequence is hardware-injected (RST/NMI/IRQ): suppress PC increment.
- `wr_inhibit`  out  1  suppress memory writes (reset sequence pushes become reads).
- `push_b`  out  1  B bit value for the pushed status byte.
- `set_i`  out  1  set P[2] this cycle.
- `vec_addr`  out  16  vector low-byte address, used by the sequencer on `vec_fetch`; high byte is at `vec_addr+1`.
- `nmi_pend`  out  1  debug/visibility: an NMI edge is latched.

## Operation
- Synchronizers: `nmi_n` and `irq_n` each pass through SYNC_STAGES flops.
- NMI edge detect: a 1→0 transition on the synchronized `nmi_n` (compared against one extra history flop) sets `nmi_pend`.
- `irq_req = !irq_n_sync && !i_flag`. The request is not latched.
- `kind` register, one of {NONE, RST, NMI, IRQ, BRK}. A separate `rst_pend` flag is set by reset.
- Evaluation when `sync=1`, in priority order:
  - `rst_pend` → kind=RST, clear `rst_pend`.
  - else `nmi_pend` → kind=NMI.
  - else `irq_req` → kind=IRQ.
  - else `opcode_in==8'h00` → kind=BRK.
  - else kind=NONE.
- `opcode_out`: 8'h00 if the evaluation selects RST, NMI or IRQ; otherwise `opcode_in`. It is combinational from the current registers and `opcode_in`.
- An injected interrupt discards the fetched opcode. The PC is not incremented, so that opcode is refetched after RTI.
- Vector selection on `vec_fetch` with kind≠NONE; the choice is registered into `vec_addr`:
  - RST → 16'hFFFC.
  - NMI → 16'hFFFA; clears `nmi_pend`.
  - IRQ or BRK with `nmi_pend=1` → 16'hFFFA (NMI hijack); clears `nmi_pend`. `push_b` is unchanged.
  - IRQ or BRK otherwise → 16'hFFFE.
- `vec_fetch` with kind=NONE: ignored, `vec_addr` holds.
- `set_i = vec_fetch && kind!=NONE`. This is combinational.
- `int_active = kind∈{RST,NMI,IRQ}`; `wr_inhibit = (kind==RST)`; `push_b = (kind==BRK)`.
- `brk_done` → kind=NONE.

## Timing
- Reset values: kind=NONE, `rst_pend=1`, `nmi_pend=0`, synchronizer and history flops=1, `vec_addr=16'hFFFC`. Resulting outputs: `opcode_out`=`opcode_in` pass-through (but see next bullet), `int_active=0`, `wr_inhibit=0`, `push_b=0`, `set_i=0`.
- First `sync` after `rst_n` deasserts: `opcode_out=8'h00`, and kind=RST from the next edge.
- NMI latency: `nmi_n` falls before edge E1; with SYNC_STAGES=2, `nmi_pend` is high after E3. An NMI pulse at least 1 clk wide is guaranteed to be caught.
- IRQ latency: SYNC_STAGES edges. `irq_n` must be held low until `sync`, or the request is lost.
- `kind` updates on the edge closing the `sync` cycle; `vec_addr` and the `nmi_pend` clear update on the edge closing the `vec_fetch` cycle.
- Simultaneous events:
  - `sync` and `brk_done` in the same cycle: `sync` evaluation wins.
  - A new NMI edge in the same cycle as the `vec_fetch` clear: `nmi_pend` stays 1.
  - `sync` during an active sequence (protocol violation): re-evaluate; the old sequence is abandoned.
- `rst_n` asserted mid-sequence: all state returns to its reset value immediately.

## Structure
- Add to `6502_defs.vh`/package:
  - `int_kind_t` enum.
  - `VEC_NMI=16'hFFFA`, `VEC_RST=16'hFFFC`, `VEC_IRQ=16'hFFFE`, `OPC_BRK=8'h00`.
- Sub-module `sync_ff` (parameterized depth, reset value 1). It is instantiated twice.
- Remaining logic is a single always_ff block plus combinational outputs.

## Test plan
- Release `rst_n`, first `sync` with `opcode_in=8'hA9` → `opcode_out=8'h00`, `wr_inhibit=1`, `int_active=1`; `vec_fetch` → `vec_addr=16'hFFFC`, `set_i=1`; `brk_done` → all flags return to 0.
- `nmi_n` low for 1 clk → `nmi_pend=1` after 3 edges; next `sync` with `opcode_in=8'hEA` → `opcode_out=8'h00`, `push_b=0`; `vec_fetch` → `vec_addr=16'hFFFA`, `nmi_pend=0`.
- `irq_n` held low:
  - with `i_flag=1`: `sync` passes `8'hEA` unchanged.
  - with `i_flag=0`: `opcode_out=8'h00`, `vec_addr=16'hFFFE`, `push_b=0`.
- Software BRK (`opcode_in=8'h00`, no pending interrupt) → `int_active=0`, `push_b=1`, `vec_addr=16'hFFFE`.
- Hijack: start a BRK sequence, raise an NMI edge before `vec_fetch` → `vec_addr=16'hFFFA`, `push_b` remains 1, `nmi_pend` cleared.
- NMI edge coincident with `vec_fetch` of an NMI sequence → `nmi_pend` stays 1; the next `sync` injects NMI again.
